// File: rtl/scara_pkg.sv
// Shared types and widths for the SCARA step-command path.
package scara_pkg;

    localparam int unsigned STEP_W = 8;
    localparam int unsigned POS_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN
    } drv_state_t;

endpackage

// File: rtl/stepper_channel.sv
// One step/dir channel: step count, period counter and pulse compare.
// Position tracking is present only when STEPPER_POS_TRACK_EN is defined.
module stepper_channel
    import scara_pkg::*;
#(
    parameter int unsigned STEP_PERIOD = 1000,
    parameter int unsigned PULSE_W     = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [STEP_W-1:0] count_in,
    input  logic              run,
    input  logic              arm,
    output logic              period_end,
    output logic              busy,
    output logic              last,
    output logic              step_out
`ifdef STEPPER_POS_TRACK_EN
    ,
    input  logic                    dir,
    output logic signed [POS_W-1:0] pos
`endif
);

    localparam int unsigned PerW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
    localparam logic [PerW-1:0] PerLast  = PerW'(STEP_PERIOD - 1);
    localparam logic [PerW-1:0] PulseEnd = PerW'(PULSE_W);

    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [PerW-1:0]   per_q, per_d;
    logic              step_q, step_d;

    always_comb begin
        period_end = run && (per_q == PerLast);
        busy       = (cnt_q != '0);
        last       = (cnt_q <= STEP_W'(1));
        cnt_d      = cnt_q;
        per_d      = '0;
        if (load) begin
            cnt_d = count_in;
        end else if (period_end && busy) begin
            cnt_d = cnt_q - STEP_W'(1);
        end
        if (run && !period_end) begin
            per_d = per_q + PerW'(1);
        end
        // Step is computed from next-cycle values so the flop output lines up with the period.
        step_d   = arm && (cnt_d != '0) && (per_d < PulseEnd);
        step_out = step_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            per_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            step_q <= step_d;
        end
    end

`ifdef STEPPER_POS_TRACK_EN
    logic signed [POS_W-1:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (step_d && !step_q) begin
            pos_d = dir ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end
        pos = pos_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end
`endif

endmodule

// File: rtl/stepper_pulse_driver.sv
// Step/dir pulse driver for the two SCARA joint steppers.
// Optional pos1/pos2 tracking is enabled by defining STEPPER_POS_TRACK_EN.
module stepper_pulse_driver
    import scara_pkg::*;
#(
    parameter int unsigned STEP_PERIOD = 1000,
    parameter int unsigned PULSE_W     = 100,
    parameter int unsigned DIR_SETUP   = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STEP_W-1:0] steps1,
    input  logic [STEP_W-1:0] steps2,
    input  logic              dir1,
    input  logic              dir2,
    input  logic              dataReady,
    output logic              stepperReady,
    output logic              step1_out,
    output logic              step2_out,
    output logic              dir1_out,
    output logic              dir2_out,
    output logic              overrun
`ifdef STEPPER_POS_TRACK_EN
    ,
    output logic signed [POS_W-1:0] pos1,
    output logic signed [POS_W-1:0] pos2
`endif
);

    localparam int unsigned SetW = $clog2(DIR_SETUP + 1);
    localparam logic [SetW-1:0] SetLast = SetW'(DIR_SETUP - 1);

    drv_state_t      state_q, state_d;
    logic [SetW-1:0] set_q, set_d;
    logic            dr_q;
    logic            rdy_q, rdy_d;
    logic            dir1_q, dir1_d, dir2_q, dir2_d;
    logic            ovr_q, ovr_d;

    logic rise, accept, run, arm;
    logic end1, end2, busy1, busy2, last1, last2;

    always_comb begin
        rise    = dataReady && !dr_q;
        accept  = rise && (state_q == IDLE);
        state_d = state_q;
        set_d   = set_q;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        ovr_d   = ovr_q || (rise && (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    set_d   = '0;
                    dir1_d  = dir1;
                    dir2_d  = dir2;
                end
            end
            SETUP: begin
                if (set_q == SetLast) begin
                    state_d = (busy1 || busy2) ? RUN : IDLE;
                end else begin
                    set_d = set_q + SetW'(1);
                end
            end
            RUN: begin
                if (end1 && end2 && last1 && last2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
        run   = (state_q == RUN);
        arm   = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            set_q   <= '0;
            dr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            dir1_q  <= 1'b0;
            dir2_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            dr_q    <= dataReady;
            rdy_q   <= rdy_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            ovr_q   <= ovr_d;
        end
    end

    assign stepperReady = rdy_q;
    assign dir1_out     = dir1_q;
    assign dir2_out     = dir2_q;
    assign overrun      = ovr_q;

    stepper_channel #(
        .STEP_PERIOD(STEP_PERIOD),
        .PULSE_W    (PULSE_W)
    ) u_ch1 (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .count_in  (steps1),
        .run       (run),
        .arm       (arm),
        .period_end(end1),
        .busy      (busy1),
        .last      (last1),
        .step_out  (step1_out)
`ifdef STEPPER_POS_TRACK_EN
        ,
        .dir       (dir1_q),
        .pos       (pos1)
`endif
    );

    stepper_channel #(
        .STEP_PERIOD(STEP_PERIOD),
        .PULSE_W    (PULSE_W)
    ) u_ch2 (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .count_in  (steps2),
        .run       (run),
        .arm       (arm),
        .period_end(end2),
        .busy      (busy2),
        .last      (last2),
        .step_out  (step2_out)
`ifdef STEPPER_POS_TRACK_EN
        ,
        .dir       (dir2_q),
        .pos       (pos2)
`endif
    );

endmodule
